// File: rtl/bbox_scan.sv
// ---------------------------------------------------------------------------
// bbox_scan: scans a WIDTH x HEIGHT image held in an external synchronous
// memory, then reports the bounding box of its foreground pixels. A pixel is
// foreground when any of its channels is >= the threshold latched at start.
//
// Optional feature macro: BBOX_COUNT_EN
//   defined   -> count reports the number of foreground pixels (saturating).
//   undefined -> no counter logic is built; count is tied to 0.
//
// Ports
//   clk                     sole clock, rising edge
//   rst                     asynchronous active-high reset
//   start                   begin a scan (honoured only when idle)
//   thresh[CH_W-1:0]        foreground threshold, latched on accepted start
//   busy                    high from the accepted start until done
//   done                    one-cycle pulse, results valid
//   rden                    memory read strobe
//   addr[23:0]              pixel address, x*HEIGHT + y (column-major)
//   rddata[CH*CH_W-1:0]     pixel data, channel 0 in LSBs, RD_LAT after rden
//   xMin/xMax/yMin/yMax     inclusive bounding-box corners of the last scan
//   found                   last scan saw at least one foreground pixel
//   count[21:0]             foreground pixel count of the last scan
// ---------------------------------------------------------------------------
module bbox_scan #(
  parameter int unsigned WIDTH  = 100,
  parameter int unsigned HEIGHT = 100,
  parameter int unsigned CH     = 3,
  parameter int unsigned CH_W   = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CH_W-1:0]    thresh,
  output logic               busy,
  output logic               done,
  output logic               rden,
  output logic [23:0]        addr,
  input  logic [CH*CH_W-1:0] rddata,
  output logic [10:0]        xMin,
  output logic [10:0]        xMax,
  output logic [10:0]        yMin,
  output logic [10:0]        yMax,
  output logic               found,
  output logic [21:0]        count
);

  localparam logic [10:0] XLast     = 11'(WIDTH - 1);
  localparam logic [10:0] YLast     = 11'(HEIGHT - 1);
  localparam logic [1:0]  DrainLast = 2'(RD_LAT - 1);
  localparam logic [10:0] CoordMax  = 11'h7FF;

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_rden;
  logic [23:0]     r_addr;
  logic [10:0]     r_x;
  logic [10:0]     r_y;
  logic [1:0]      r_drain;
  logic [CH_W-1:0] r_thresh;

  // Result registers, held between done pulses.
  logic [10:0]     r_xmin;
  logic [10:0]     r_xmax;
  logic [10:0]     r_ymin;
  logic [10:0]     r_ymax;
  logic            r_found;

  // Coordinate pipeline that travels alongside each outstanding read.
  logic [RD_LAT-1:0] r_pv;
  logic [10:0]       r_px [RD_LAT];
  logic [10:0]       r_py [RD_LAT];

  // Working accumulators for the scan in progress.
  logic [10:0]     r_wxmin;
  logic [10:0]     r_wxmax;
  logic [10:0]     r_wymin;
  logic [10:0]     r_wymax;
  logic            r_wfound;

  logic            w_fg;
  logic            w_hit;
  logic [10:0]     w_sx;
  logic [10:0]     w_sy;
  logic            w_accept;

  assign w_accept = (r_state == StIdle) && start;

  // Any channel at or above the threshold marks a foreground pixel.
  always_comb begin
    w_fg = 1'b0;
    for (int c = 0; c < int'(CH); c++) begin
      if (rddata[c*CH_W +: CH_W] >= r_thresh) begin
        w_fg = 1'b1;
      end
    end
  end

  assign w_sx  = r_px[RD_LAT-1];
  assign w_sy  = r_py[RD_LAT-1];
  assign w_hit = r_pv[RD_LAT-1] && w_fg;

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rden   <= 1'b0;
      r_addr   <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_drain  <= '0;
      r_thresh <= '0;
      r_xmin   <= '0;
      r_xmax   <= '0;
      r_ymin   <= '0;
      r_ymax   <= '0;
      r_found  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_thresh <= thresh;
            r_x      <= '0;
            r_y      <= '0;
            r_addr   <= '0;
            r_rden   <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= StScan;
          end
        end
        StScan: begin
          if ((r_x == XLast) && (r_y == YLast)) begin
            // Final address has been issued; wait for its data to return.
            r_rden  <= 1'b0;
            r_addr  <= '0;
            r_drain <= '0;
            r_state <= StDrain;
          end else begin
            // Column-major order with y innermost is a plain linear address.
            r_addr <= r_addr + 24'd1;
            if (r_y == YLast) begin
              r_y <= '0;
              r_x <= r_x + 11'd1;
            end else begin
              r_y <= r_y + 11'd1;
            end
          end
        end
        StDrain: begin
          if (r_drain == DrainLast) begin
            r_state <= StDone;
          end else begin
            r_drain <= r_drain + 2'd1;
          end
        end
        StDone: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_found <= r_wfound;
          // An empty scan reports a zero box rather than the 2047/0 init values.
          r_xmin  <= r_wfound ? r_wxmin : 11'd0;
          r_xmax  <= r_wfound ? r_wxmax : 11'd0;
          r_ymin  <= r_wfound ? r_wymin : 11'd0;
          r_ymax  <= r_wfound ? r_wymax : 11'd0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Read-coordinate pipeline and working min/max accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv     <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        r_px[i] <= '0;
        r_py[i] <= '0;
      end
      r_wxmin  <= CoordMax;
      r_wxmax  <= '0;
      r_wymin  <= CoordMax;
      r_wymax  <= '0;
      r_wfound <= 1'b0;
    end else begin
      r_pv[0] <= r_rden;
      r_px[0] <= r_x;
      r_py[0] <= r_y;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_pv[i] <= r_pv[i-1];
        r_px[i] <= r_px[i-1];
        r_py[i] <= r_py[i-1];
      end

      if (w_accept) begin
        r_wxmin  <= CoordMax;
        r_wxmax  <= '0;
        r_wymin  <= CoordMax;
        r_wymax  <= '0;
        r_wfound <= 1'b0;
      end else if (w_hit) begin
        r_wfound <= 1'b1;
        if (w_sx < r_wxmin) r_wxmin <= w_sx;
        if (w_sx > r_wxmax) r_wxmax <= w_sx;
        if (w_sy < r_wymin) r_wymin <= w_sy;
        if (w_sy > r_wymax) r_wymax <= w_sy;
      end
    end
  end

`ifdef BBOX_COUNT_EN
  logic [21:0] r_wcnt;
  logic [21:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_wcnt <= '0;
      end else if (w_hit && (r_wcnt != 22'h3FFFFF)) begin
        // Saturate rather than wrap on very large images.
        r_wcnt <= r_wcnt + 22'd1;
      end
      if (r_state == StDone) begin
        r_count <= r_wcnt;
      end
    end
  end

  assign count = r_count;
`else
  assign count = 22'd0;
`endif

  assign busy  = r_busy;
  assign done  = r_done;
  assign rden  = r_rden;
  assign addr  = r_addr;
  assign xMin  = r_xmin;
  assign xMax  = r_xmax;
  assign yMin  = r_ymin;
  assign yMax  = r_ymax;
  assign found = r_found;

endmodule

// File: tb/tb_bbox_scan.sv
// ---------------------------------------------------------------------------
// tb_bbox_scan: directed bench for bbox_scan on a 4x3, 3-channel image with a
// two-cycle memory. Expected results come from a behavioural bounding-box
// model pushed into a queue at start and popped when done pulses.
// ---------------------------------------------------------------------------
module tb_bbox_scan;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CH = 3;
  localparam int CW = 8;
  localparam int RL = 2;
  localparam int N  = W * H;
  localparam int LAT = N + RL + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  thresh;
  logic        busy, done, rden, found;
  logic [23:0] addr;
  logic [23:0] rddata;
  logic [10:0] xMin, xMax, yMin, yMax;
  logic [21:0] count;

  bbox_scan #(
    .WIDTH (W),
    .HEIGHT(H),
    .CH    (CH),
    .CH_W  (CW),
    .RD_LAT(RL)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .thresh(thresh),
    .busy  (busy),
    .done  (done),
    .rden  (rden),
    .addr  (addr),
    .rddata(rddata),
    .xMin  (xMin),
    .xMax  (xMax),
    .yMin  (yMin),
    .yMax  (yMax),
    .found (found),
    .count (count)
  );

  always #5 clk = ~clk;

  // Two-stage memory; returns all-ones when not read so stray samples show up.
  logic [23:0] mem [N];
  logic [23:0] m0, m1;
  always @(posedge clk) begin
    m0 <= (rden && addr < 24'(N)) ? mem[addr[3:0]] : 24'hFFFFFF;
    m1 <= m0;
  end
  assign rddata = m1;

  typedef struct packed {
    logic        fnd;
    logic [10:0] x0;
    logic [10:0] x1;
    logic [10:0] y0;
    logic [10:0] y1;
    logic [21:0] cnt;
  } res_t;

  res_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [7:0] th);
    res_t r;
    int c = 0;
    int mnx = 2047, mxx = 0, mny = 2047, mxy = 0;
    for (int x = 0; x < W; x++) begin
      for (int y = 0; y < H; y++) begin
        logic [23:0] p;
        p = mem[x*H + y];
        if (p[7:0] >= th || p[15:8] >= th || p[23:16] >= th) begin
          c++;
          if (x < mnx) mnx = x;
          if (x > mxx) mxx = x;
          if (y < mny) mny = y;
          if (y > mxy) mxy = y;
        end
      end
    end
    r.fnd = (c > 0);
    r.x0  = r.fnd ? 11'(mnx) : 11'd0;
    r.x1  = r.fnd ? 11'(mxx) : 11'd0;
    r.y0  = r.fnd ? 11'(mny) : 11'd0;
    r.y1  = r.fnd ? 11'(mxy) : 11'd0;
`ifdef BBOX_COUNT_EN
    r.cnt = 22'(c);
`else
    r.cnt = 22'd0;
`endif
    return r;
  endfunction

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, ":found"}, 32'(found), 32'(e.fnd));
    chk({tag, ":xMin"},  32'(xMin),  32'(e.x0));
    chk({tag, ":xMax"},  32'(xMax),  32'(e.x1));
    chk({tag, ":yMin"},  32'(yMin),  32'(e.y0));
    chk({tag, ":yMax"},  32'(yMax),  32'(e.y1));
    chk({tag, ":count"}, 32'(count), 32'(e.cnt));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = 24'h0;
  endtask

  // One scan with thresh=5. start2_at re-pulses start at that scan cycle;
  // rst_at aborts the scan with reset at that cycle.
  task automatic run_scan(input string tag, input int start2_at, input int rst_at);
    res_t e;
    bit   seen = 1'b0;
    int   pulses;
    if (rst_at == 0) q.push_back(model(8'd5));
    thresh = 8'd5;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    thresh = 8'hFF;  // must not affect the scan already accepted
    chk({tag, ":busy_start"}, 32'(busy), 32'd1);
    chk({tag, ":rden_start"}, 32'(rden), 32'd1);
    chk({tag, ":addr_start"}, 32'(addr), 32'd0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      start = (cyc == start2_at);
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk({tag, ":rst_busy"}, 32'(busy), 32'd0);
        chk({tag, ":rst_rden"}, 32'(rden), 32'd0);
        chk({tag, ":rst_addr"}, 32'(addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
          @(posedge clk); #1;
          if (done) pulses++;
        end
        chk({tag, ":no_done"}, 32'(pulses), 32'd0);
        chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ":rst_found"}, 32'(found), 32'd0);
        chk({tag, ":rst_xMax"}, 32'(xMax), 32'd0);
        return;
      end
      if (cyc < N) begin
        chk({tag, ":rden"}, 32'(rden), 32'd1);
        chk($sformatf("%s:addr%0d", tag, cyc), 32'(addr), 32'(cyc));
      end else begin
        chk({tag, ":rden_off"}, 32'(rden), 32'd0);
        chk({tag, ":addr_off"}, 32'(addr), 32'd0);
      end
      chk($sformatf("%s:busy%0d", tag, cyc), 32'(busy), (cyc < LAT) ? 32'd1 : 32'd0);
      if (done) begin
        seen = 1'b1;
        chk({tag, ":latency"}, 32'(cyc), 32'(LAT));
        chk({tag, ":queue"}, 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk_res(tag, e);
        end
        break;
      end
    end
    chk({tag, ":done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (done) pulses++;
      end
      chk({tag, ":single_done"}, 32'(pulses), 32'd0);
      chk_res({tag, ":hold"}, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    thresh = 8'd0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("reset:busy",  32'(busy),  32'd0);
    chk("reset:done",  32'(done),  32'd0);
    chk("reset:rden",  32'(rden),  32'd0);
    chk("reset:addr",  32'(addr),  32'd0);
    chk("reset:found", 32'(found), 32'd0);
    chk("reset:count", 32'(count), 32'd0);
    chk("reset:xMin",  32'(xMin),  32'd0);
    chk("reset:yMax",  32'(yMax),  32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Empty image.
    run_scan("zero", 0, 0);

    // Single pixel at x=2, y=1 exactly at threshold.
    clear_mem();
    mem[7] = 24'h000005;
    run_scan("single", 0, 0);

    // Opposite corners plus a sub-threshold pixel.
    clear_mem();
    mem[0]  = 24'h0A0000;
    mem[11] = 24'h0000FF;
    mem[5]  = 24'h040404;
    run_scan("box", 0, 0);

    // Start re-pulsed mid-scan must be ignored.
    run_scan("restart", 5, 0);

    // Abort with reset, then a clean full scan.
    run_scan("abort", 0, 6);
    run_scan("after_abort", 0, 0);

    // Random sparse images.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) mem[i] = 24'($urandom) & 24'h070707;
      run_scan($sformatf("rand%0d", r), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
